// File: rtl/icache_controller_if.sv
// CPU-fetch and instruction-memory signal bundle for the instruction cache controller.
// slave = controller side, master = CPU/memory side.
interface icache_controller_if #(
  parameter int ADDR_W = 10
);
  localparam int MEM_AW = ADDR_W - 4;

  logic              cpu_read;
  logic [ADDR_W-1:0] cpu_address;
  logic [31:0]       instruction;
  logic              busywait;
  logic              mem_read;
  logic [MEM_AW-1:0] mem_address;
  logic [127:0]      mem_readdata;
  logic              mem_busywait;
  logic [15:0]       miss_count;

  modport slave (
    input  cpu_read, cpu_address, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address, miss_count
  );

  modport master (
    output cpu_read, cpu_address, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address, miss_count
  );
endinterface

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, blocking 128-bit miss fill.
// Miss latency 3 + memory busy cycles; CPU stalled via busywait, memory paced by mem_busywait.
module icache_controller #(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  icache_controller_if.slave  bus
);
  localparam int TAG_W  = ADDR_W - 4 - INDEX_W;
  localparam int MEM_AW = ADDR_W - 4;
  localparam int NBLK   = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [127:0]        r_data [NBLK];
  logic [TAG_W-1:0]    r_tag  [NBLK];
  logic [NBLK-1:0]     r_valid;
  logic [TAG_W-1:0]    r_req_tag;
  logic [INDEX_W-1:0]  r_req_index;
  logic [15:0]         r_miss_count;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [1:0]          w_offset;
  logic                w_hit;
  logic [127:0]        w_block;
  logic                w_miss;
  logic                w_fill;
  logic                w_busywait;
  logic                w_mem_read;
  logic [MEM_AW-1:0]   w_mem_address;
  logic                w_unused_bits;

  assign w_tag    = bus.cpu_address[ADDR_W-1 -: TAG_W];
  assign w_index  = bus.cpu_address[4 +: INDEX_W];
  assign w_offset = bus.cpu_address[3:2];
  assign w_unused_bits = &{1'b0, bus.cpu_address[1:0]};

  assign w_hit   = bus.cpu_read & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_block = r_data[w_index];
  assign w_miss  = (r_state == IDLE) & bus.cpu_read & ~w_hit;

  always_comb begin
    w_next_state  = r_state;
    w_busywait    = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_address = '0;
    w_fill        = 1'b0;
    case (r_state)
      IDLE: begin
        w_busywait = bus.cpu_read & ~w_hit;
        if (w_miss) w_next_state = MEM_READ;
      end
      MEM_READ: begin
        w_busywait    = 1'b1;
        w_mem_read    = 1'b1;
        w_mem_address = {r_req_tag, r_req_index};
        if (!bus.mem_busywait) begin
          w_fill       = 1'b1;
          w_next_state = UPDATE;
        end
      end
      UPDATE: begin
        w_busywait   = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_req_tag    <= '0;
      r_req_index  <= '0;
      r_miss_count <= '0;
    end else if (w_miss) begin
      r_req_tag   <= w_tag;
      r_req_index <= w_index;
      if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_valid <= '0;
    else if (w_fill) r_valid[r_req_index] <= 1'b1;
  end

  // Block payload and tags carry no reset; valid alone decides whether they are meaningful.
  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_data[r_req_index] <= bus.mem_readdata;
      r_tag[r_req_index]  <= r_req_tag;
    end
  end

  assign bus.instruction = w_hit ? w_block[{w_offset, 5'd0} +: 32] : 32'h0;
  // A CPU that keeps cpu_read high across reset must not see a stall while reset is held.
  assign bus.busywait    = reset & w_busywait;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_address = w_mem_address;
  assign bus.miss_count  = r_miss_count;
endmodule
